// File: rtl/qrd_stream_checker_if.sv
// Stream-checker bus: run control, golden/DUT lanes and result reporting.
// The slave modport is the checker side; the master modport is the test-harness side.
interface qrd_stream_checker_if #(
    parameter int N_CH  = 4,
    parameter int W     = 17,
    parameter int LAT_W = 5,
    parameter int CNT_W = 16,
    parameter int CH_W  = 2
);
    logic                  start;
    logic [LAT_W-1:0]      lat_cfg;
    logic [CNT_W-1:0]      num_pat;
    logic                  gold_valid;
    logic [N_CH*W-1:0]     gold_data;
    logic [N_CH*W-1:0]     dut_data;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic                  mismatch;
    logic [CNT_W-1:0]      err_cnt;
    logic [CNT_W-1:0]      chk_cnt;
    logic [CNT_W-1:0]      first_fail_idx;
    logic [CH_W-1:0]       first_fail_ch;

    modport slave (
        input  start, lat_cfg, num_pat, gold_valid, gold_data, dut_data,
        output busy, done, pass, mismatch, err_cnt, chk_cnt, first_fail_idx, first_fail_ch
    );

    modport master (
        output start, lat_cfg, num_pat, gold_valid, gold_data, dut_data,
        input  busy, done, pass, mismatch, err_cnt, chk_cnt, first_fail_idx, first_fail_ch
    );
endinterface

// File: rtl/qrd_stream_checker.sv
// Lane-wise response checker for streaming QRD datapaths: delays golden samples by a
// programmable latency and compares them with the DUT stream. Define QRD_CHK_TOL_EN for |diff| <= TOL.
module qrd_stream_checker #(
    parameter int N_CH    = 4,
    parameter int W       = 17,
    parameter int LAT_MAX = 16,
    parameter int LAT_W   = 5,
    parameter int CNT_W   = 16,
    parameter int CH_W    = 2,
    parameter int TOL     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    qrd_stream_checker_if.slave  chk_if
);

    localparam int DW    = N_CH * W;
    localparam int IDX_W = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
`ifdef QRD_CHK_TOL_EN
    localparam bit TOL_EN = 1'b1;
`else
    localparam bit TOL_EN = 1'b0;
`endif
    // A zero tolerance makes the magnitude test identical to a bit-exact compare.
    localparam int unsigned TOL_EFF = TOL_EN ? TOL : 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   lat_q;
    logic [CNT_W-1:0]   num_pat_q;
    logic [CNT_W-1:0]   push_cnt_q, push_cnt_d;
    logic [CNT_W-1:0]   chk_cnt_q, chk_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   ffi_q, ffi_d;
    logic [CH_W-1:0]    ffc_q, ffc_d;
    logic               mismatch_q, mismatch_d;
    logic               busy_q, done_q, pass_q;
    logic [DW:0]        dl_q [LAT_MAX];
    logic               cmp_vld_q, cmp_fail_q;
    logic [CH_W-1:0]    cmp_ch_q;

    logic               start_take_s, push_s, run_s, cmp_fire_s, cmp_fail_s;
    logic [LAT_W-1:0]   lat_clamp_s;
    logic [DW:0]        tap_s;
    logic [N_CH-1:0]    lane_fail_s;
    logic [CH_W-1:0]    cmp_ch_s;

    // Signed W-bit lanes, difference taken at W+1 bits so extremes cannot overflow.
    function automatic logic lane_fail(input logic [W-1:0] gold, input logic [W-1:0] dut);
        logic [W:0] diff;
        logic [W:0] mag;
        diff = {dut[W-1], dut} - {gold[W-1], gold};
        mag  = diff[W] ? (~diff + (W+1)'(1)) : diff;
        return (mag > (W+1)'(TOL_EFF));
    endfunction

    // Run control, push gating and latency clamp.
    always_comb begin
        run_s        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        start_take_s = chk_if.start && !run_s;
        push_s       = (state_q == ST_RUN) && chk_if.gold_valid && (push_cnt_q != num_pat_q);
        lat_clamp_s  = (chk_if.lat_cfg > LAT_W'(LAT_MAX)) ? LAT_W'(LAT_MAX) : chk_if.lat_cfg;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_take_s) begin
                    state_d = (chk_if.num_pat == '0) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (push_cnt_q == num_pat_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (chk_cnt_q == num_pat_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Delay-line tap and lane comparison; lat 0 bypasses the line entirely.
    always_comb begin
        if (lat_q == '0) begin
            tap_s = {push_s, chk_if.gold_data};
        end else begin
            tap_s = dl_q[IDX_W'(lat_q - LAT_W'(1))];
        end
        for (int k = 0; k < N_CH; k++) begin
            lane_fail_s[k] = lane_fail(tap_s[k*W +: W], chk_if.dut_data[k*W +: W]);
        end
        cmp_ch_s = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            cmp_ch_s = lane_fail_s[k] ? CH_W'(k) : cmp_ch_s;
        end
        cmp_fail_s = |lane_fail_s;
        cmp_fire_s = run_s && tap_s[DW];
    end

    // Result counters and first-failure capture, fed by the registered compare.
    always_comb begin
        push_cnt_d = push_cnt_q;
        chk_cnt_d  = chk_cnt_q;
        err_cnt_d  = err_cnt_q;
        ffi_d      = ffi_q;
        ffc_d      = ffc_q;
        mismatch_d = 1'b0;
        if (start_take_s) begin
            push_cnt_d = '0;
            chk_cnt_d  = '0;
            err_cnt_d  = '0;
            ffi_d      = '1;
            ffc_d      = '0;
        end else begin
            push_cnt_d = push_s ? (push_cnt_q + CNT_W'(1)) : push_cnt_q;
            if (cmp_vld_q) begin
                chk_cnt_d = chk_cnt_q + CNT_W'(1);
                if (cmp_fail_q) begin
                    mismatch_d = 1'b1;
                    err_cnt_d  = (err_cnt_q == '1) ? err_cnt_q : (err_cnt_q + CNT_W'(1));
                    ffi_d      = (err_cnt_q == '0) ? chk_cnt_q : ffi_q;
                    ffc_d      = (err_cnt_q == '0) ? cmp_ch_q : ffc_q;
                end else begin
                    mismatch_d = 1'b0;
                end
            end else begin
                chk_cnt_d = chk_cnt_q;
            end
        end
    end

    // FSM state, run configuration and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lat_q     <= '0;
            num_pat_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_q     <= start_take_s ? lat_clamp_s : lat_q;
            num_pat_q <= start_take_s ? chk_if.num_pat : num_pat_q;
            busy_q    <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            done_q    <= (state_d == ST_DONE);
            pass_q    <= (state_d == ST_DONE) && (err_cnt_d == '0);
        end
    end

    // Counter and report registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_cnt_q <= '0;
            chk_cnt_q  <= '0;
            err_cnt_q  <= '0;
            ffi_q      <= '1;
            ffc_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            push_cnt_q <= push_cnt_d;
            chk_cnt_q  <= chk_cnt_d;
            err_cnt_q  <= err_cnt_d;
            ffi_q      <= ffi_d;
            ffc_q      <= ffc_d;
            mismatch_q <= mismatch_d;
        end
    end

    // Compare pipeline stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_vld_q  <= 1'b0;
            cmp_fail_q <= 1'b0;
            cmp_ch_q   <= '0;
        end else begin
            cmp_vld_q  <= cmp_fire_s;
            cmp_fail_q <= cmp_fire_s && cmp_fail_s;
            cmp_ch_q   <= cmp_ch_s;
        end
    end

    // Gold delay line; a new run flushes it so nothing stale can be compared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT_MAX; i++) begin
                dl_q[i] <= '0;
            end
        end else if (start_take_s) begin
            for (int i = 0; i < LAT_MAX; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            dl_q[0] <= {push_s, chk_if.gold_data};
            for (int i = 1; i < LAT_MAX; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    assign chk_if.busy           = busy_q;
    assign chk_if.done           = done_q;
    assign chk_if.pass           = pass_q;
    assign chk_if.mismatch       = mismatch_q;
    assign chk_if.err_cnt        = err_cnt_q;
    assign chk_if.chk_cnt        = chk_cnt_q;
    assign chk_if.first_fail_idx = ffi_q;
    assign chk_if.first_fail_ch  = ffc_q;

endmodule

// File: tb/tb_qrd_stream_checker.sv
// Directed bench for qrd_stream_checker: default instance plus a CNT_W=4 instance.
// Expected values follow the build mode (QRD_CHK_TOL_EN changes the +1 LSB case only).
module tb_qrd_stream_checker;

    localparam int N_CH = 4;
    localparam int W    = 17;
    localparam int DW   = N_CH * W;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   pulses;

    qrd_stream_checker_if #(.N_CH(4), .W(17), .LAT_W(5), .CNT_W(16), .CH_W(2)) bus ();
    qrd_stream_checker_if #(.N_CH(4), .W(17), .LAT_W(5), .CNT_W(4),  .CH_W(2)) bus4 ();

    qrd_stream_checker #(.N_CH(4), .W(17), .LAT_MAX(16), .LAT_W(5), .CNT_W(16), .CH_W(2), .TOL(1))
        u_dut (.clk(clk), .rst_n(rst_n), .chk_if(bus));
    qrd_stream_checker #(.N_CH(4), .W(17), .LAT_MAX(16), .LAT_W(5), .CNT_W(4), .CH_W(2), .TOL(1))
        u_dut4 (.clk(clk), .rst_n(rst_n), .chk_if(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] gval(input int p);
        logic [DW-1:0] v;
        for (int k = 0; k < N_CH; k++) begin
            v[k*W +: W] = 17'((p * 4 + k + 1) * 12345 + p * 777);
        end
        return v;
    endfunction

    // One run on the default instance; dut_data is the bench's own delayed copy of gold.
    task automatic run_pattern(input int lat_in, input int lat_eff, input int np, input bit toggle,
                               input bit fixed, input int bad_pat, input int bad_lane,
                               input int busy_c, input string tag, output int npulse);
        int push_at [0:79];
        int pushed;
        int p;
        bit finished;
        logic [DW-1:0] dv;
        for (int i = 0; i < 80; i++) push_at[i] = -1;
        pushed = 0;
        npulse = 0;
        finished = 1'b0;
        @(negedge clk);
        bus.lat_cfg = 5'(lat_in);
        bus.num_pat = 16'(np);
        bus.start = 1'b1;
        bus.gold_valid = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 0; c < 80 && !finished; c++) begin
            if (bus.done === 1'b1) begin
                finished = 1'b1;
            end else begin
                npulse += int'(bus.mismatch);
                if (pushed < np && (!toggle || (c % 2) == 0)) begin
                    bus.gold_valid = 1'b1;
                    bus.gold_data = fixed ? {4{17'h10000}} : gval(pushed);
                    push_at[c] = pushed;
                    pushed++;
                end else begin
                    bus.gold_valid = 1'b0;
                    bus.gold_data = {4{17'h15555}};
                end
                p = (c >= lat_eff) ? push_at[c - lat_eff] : -1;
                if (p >= 0) begin
                    dv = fixed ? {4{17'h0FFFF}} : gval(p);
                    if (p == bad_pat) dv[bad_lane*W +: W] = dv[bad_lane*W +: W] + 17'd1;
                    bus.dut_data = dv;
                end else begin
                    bus.dut_data = {4{17'h0AAAA}};
                end
                if (c == busy_c) begin
                    bus.start = 1'b1;
                    bus.lat_cfg = 5'd0;
                    bus.num_pat = 16'd1;
                end else begin
                    bus.start = 1'b0;
                end
                @(negedge clk);
            end
        end
        bus.gold_valid = 1'b0;
        bus.start = 1'b0;
        check({tag, "_timeout"}, 32'(finished), 32'd1);
    endtask

    // One run on the CNT_W=4 instance: lat 0, 15 patterns, every lane off by 2.
    task automatic run_small(input string tag);
        bit finished;
        finished = 1'b0;
        pulses = 0;
        @(negedge clk);
        bus4.lat_cfg = 5'd0;
        bus4.num_pat = 4'd15;
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        bus4.gold_valid = 1'b1;
        bus4.gold_data = '0;
        bus4.dut_data = {4{17'h00002}};
        for (int c = 0; c < 40 && !finished; c++) begin
            if (bus4.done === 1'b1) begin
                finished = 1'b1;
            end else begin
                pulses += int'(bus4.mismatch);
                @(negedge clk);
            end
        end
        bus4.gold_valid = 1'b0;
        check({tag, "_timeout"}, 32'(finished), 32'd1);
        check({tag, "_err"}, 32'(bus4.err_cnt), 32'd15);
        check({tag, "_chk"}, 32'(bus4.chk_cnt), 32'd15);
        check({tag, "_ffi"}, 32'(bus4.first_fail_idx), 32'd0);
        check({tag, "_pass"}, 32'(bus4.pass), 32'd0);
        check({tag, "_pulses"}, 32'(pulses), 32'd15);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;  bus.lat_cfg = '0;  bus.num_pat = '0;
        bus.gold_valid = 1'b0;  bus.gold_data = '0;  bus.dut_data = '0;
        bus4.start = 1'b0; bus4.lat_cfg = '0; bus4.num_pat = '0;
        bus4.gold_valid = 1'b0; bus4.gold_data = '0; bus4.dut_data = '0;

        // Reset state
        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_pass", 32'(bus.pass), 32'd0);
        check("rst_mism", 32'(bus.mismatch), 32'd0);
        check("rst_err", 32'(bus.err_cnt), 32'd0);
        check("rst_chk", 32'(bus.chk_cnt), 32'd0);
        check("rst_ffi", 32'(bus.first_fail_idx), 32'h0000FFFF);
        check("rst_ffc", 32'(bus.first_fail_ch), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean run, lat 6
        run_pattern(6, 6, 8, 1'b0, 1'b0, -1, 0, -1, "t1", pulses);
        check("t1_chk", 32'(bus.chk_cnt), 32'd8);
        check("t1_err", 32'(bus.err_cnt), 32'd0);
        check("t1_pass", 32'(bus.pass), 32'd1);
        check("t1_ffi", 32'(bus.first_fail_idx), 32'h0000FFFF);
        check("t1_busy", 32'(bus.busy), 32'd0);
        check("t1_pulses", 32'(pulses), 32'd0);

        // Lane 2 of pattern 3 off by +1 LSB
        run_pattern(6, 6, 8, 1'b0, 1'b0, 3, 2, -1, "t2", pulses);
        check("t2_chk", 32'(bus.chk_cnt), 32'd8);
`ifdef QRD_CHK_TOL_EN
        check("t2_err", 32'(bus.err_cnt), 32'd0);
        check("t2_pass", 32'(bus.pass), 32'd1);
        check("t2_ffi", 32'(bus.first_fail_idx), 32'h0000FFFF);
        check("t2_pulses", 32'(pulses), 32'd0);
`else
        check("t2_err", 32'(bus.err_cnt), 32'd1);
        check("t2_pass", 32'(bus.pass), 32'd0);
        check("t2_ffi", 32'(bus.first_fail_idx), 32'd3);
        check("t2_ffc", 32'(bus.first_fail_ch), 32'd2);
        check("t2_pulses", 32'(pulses), 32'd1);
`endif

        // lat 0, gold_valid toggling, extreme lanes 17'h10000 vs 17'h0FFFF
        run_pattern(0, 0, 4, 1'b1, 1'b1, -1, 0, -1, "t3", pulses);
        check("t3_chk", 32'(bus.chk_cnt), 32'd4);
        check("t3_err", 32'(bus.err_cnt), 32'd4);
        check("t3_pass", 32'(bus.pass), 32'd0);
        check("t3_ffi", 32'(bus.first_fail_idx), 32'd0);
        check("t3_ffc", 32'(bus.first_fail_ch), 32'd0);
        check("t3_pulses", 32'(pulses), 32'd4);

        // lat 20 clamps to 16; a start mid-run must be ignored
        run_pattern(20, 16, 5, 1'b0, 1'b0, -1, 0, 2, "t4", pulses);
        check("t4_chk", 32'(bus.chk_cnt), 32'd5);
        check("t4_err", 32'(bus.err_cnt), 32'd0);
        check("t4_pass", 32'(bus.pass), 32'd1);

        // num_pat 0 completes one cycle after start
        @(negedge clk);
        bus.num_pat = 16'd0;
        bus.lat_cfg = 5'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("t5_done", 32'(bus.done), 32'd1);
        check("t5_pass", 32'(bus.pass), 32'd1);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_chk", 32'(bus.chk_cnt), 32'd0);

        // Reset during DRAIN, then a clean run
        @(negedge clk);
        bus.lat_cfg = 5'd16;
        bus.num_pat = 16'd2;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.gold_valid = 1'b1;
        bus.gold_data = gval(0);
        @(negedge clk);
        bus.gold_data = gval(1);
        @(negedge clk);
        bus.gold_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_busy_pre", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_done", 32'(bus.done), 32'd0);
        check("t6_chk", 32'(bus.chk_cnt), 32'd0);
        check("t6_ffi", 32'(bus.first_fail_idx), 32'h0000FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        run_pattern(6, 6, 8, 1'b0, 1'b0, -1, 0, -1, "t6r", pulses);
        check("t6r_chk", 32'(bus.chk_cnt), 32'd8);
        check("t6r_err", 32'(bus.err_cnt), 32'd0);
        check("t6r_pass", 32'(bus.pass), 32'd1);

        // CNT_W=4, all compares failing, two back-to-back runs
        run_small("t7a");
        run_small("t7b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
